// File: rtl/lvds_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lvds_pkg : state encodings, counter width and helpers for the link supervisor
// Revision : 1.0
// ---------------------------------------------------------------------------
package lvds_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_READY = 3'd1;
  localparam logic [2:0] ST_FLUSH      = 3'd2;
  localparam logic [2:0] ST_ALIGN      = 3'd3;
  localparam logic [2:0] ST_RUN        = 3'd4;
  localparam logic [2:0] ST_HOLDOFF    = 3'd5;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage : lvds_pkg
`default_nettype wire

// File: rtl/lvds_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lvds_sat_counter : saturating health counter, clear beats increment
// Revision : 1.0
// ---------------------------------------------------------------------------
module lvds_sat_counter
  import lvds_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output cnt_t count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + cnt_t'(1);
    end
  end

endmodule : lvds_sat_counter
`default_nettype wire

// File: rtl/lvds_link_supervisor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lvds_link_supervisor : bring-up / recovery sequencer for the LVDS RX path
// Revision : 1.0
// ---------------------------------------------------------------------------
module lvds_link_supervisor
  import lvds_pkg::*;
#(
  parameter int FLUSH_CYCLES   = 16,
  parameter int ALIGN_TIMEOUT  = 1024,
  parameter int HOLDOFF_CYCLES = 256
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic       i_cfg_en,
  input  logic       i_lvds_ready,
  input  logic       i_sync_found,
  input  logic       i_clr_cnt,
  output logic       o_fifo_flush,
  output logic       o_align_en,
  output logic       o_rx_enable,
  output logic       o_link_up,
  output logic [2:0] o_state,
  output cnt_t       o_dropout_cnt,
  output cnt_t       o_align_fail_cnt
);

  localparam int TMR_MAX = max3(FLUSH_CYCLES, ALIGN_TIMEOUT, HOLDOFF_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  // Loads are N-1 so that a timed state lasts exactly N cycles, exiting at 0.
  localparam logic [TMR_W-1:0] FLUSH_LOAD   = TMR_W'(FLUSH_CYCLES - 1);
  localparam logic [TMR_W-1:0] ALIGN_LOAD   = TMR_W'(ALIGN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLDOFF_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic [TMR_W-1:0] timer_dec;
  logic             timer_done;
  logic             dropout_inc;
  logic             align_fail_inc;

  assign timer_done = (timer == '0);
  assign timer_dec  = timer_done ? '0 : timer - TMR_W'(1);

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    dropout_inc    = 1'b0;
    align_fail_inc = 1'b0;
    if (!i_cfg_en) begin
      state_nxt = ST_IDLE;
      timer_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_WAIT_READY;
        end
        ST_WAIT_READY: begin
          if (i_lvds_ready) begin
            state_nxt = ST_FLUSH;
            timer_nxt = FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (!i_lvds_ready) begin
            state_nxt = ST_HOLDOFF;
            timer_nxt = HOLDOFF_LOAD;
          end else if (timer_done) begin
            state_nxt = ST_ALIGN;
            timer_nxt = ALIGN_LOAD;
          end else begin
            timer_nxt = timer_dec;
          end
        end
        ST_ALIGN: begin
          // Sync is checked before the timeout so a lock on the last cycle wins.
          if (!i_lvds_ready) begin
            state_nxt = ST_HOLDOFF;
            timer_nxt = HOLDOFF_LOAD;
          end else if (i_sync_found) begin
            state_nxt = ST_RUN;
            timer_nxt = '0;
          end else if (timer_done) begin
            state_nxt      = ST_HOLDOFF;
            timer_nxt      = HOLDOFF_LOAD;
            align_fail_inc = 1'b1;
          end else begin
            timer_nxt = timer_dec;
          end
        end
        ST_RUN: begin
          if (!i_lvds_ready) begin
            state_nxt   = ST_HOLDOFF;
            timer_nxt   = HOLDOFF_LOAD;
            dropout_inc = 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (timer_done) begin
            state_nxt = ST_WAIT_READY;
          end else begin
            timer_nxt = timer_dec;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state        <= ST_IDLE;
      timer        <= '0;
      o_fifo_flush <= 1'b0;
      o_align_en   <= 1'b0;
      o_rx_enable  <= 1'b0;
      o_link_up    <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      o_fifo_flush <= (state_nxt == ST_FLUSH);
      o_align_en   <= (state_nxt == ST_ALIGN);
      o_rx_enable  <= (state_nxt == ST_RUN);
      o_link_up    <= (state_nxt == ST_RUN);
    end
  end

  assign o_state = state;

  lvds_sat_counter u_dropout_cnt (
    .clk   (i_sys_clk),
    .rst_n (i_rst_b),
    .inc   (dropout_inc),
    .clr   (i_clr_cnt),
    .count (o_dropout_cnt)
  );

  lvds_sat_counter u_align_fail_cnt (
    .clk   (i_sys_clk),
    .rst_n (i_rst_b),
    .inc   (align_fail_inc),
    .clr   (i_clr_cnt),
    .count (o_align_fail_cnt)
  );

endmodule : lvds_link_supervisor
`default_nettype wire
